cnn_output_collector: RTL and testbench
=======================================

CNN_OUTPUT_COLLECTOR -- requirements
Module: cnn_output_collector

Interface
REQ-001 SHALL have parameter PIXEL_BIT_WIDTH, default 12, meaning width of each CNN output word (signed two's complement).
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, meaning width of the frame counter.
REQ-003 SHALL have port ap_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port ap_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cnn_output_k_TDATA  input  PIXEL_BIT_WIDTH  CNN score k, for k = 0..4.
REQ-006 SHALL have ports cnn_output_k_TVALID  input  1  score k valid, for k = 0..4.
REQ-007 SHALL have ports cnn_output_k_TREADY  output  1  collector accepts score k, for k = 0..4.
REQ-008 SHALL have port result_TDATA  output  5*PIXEL_BIT_WIDTH  packed scores; score k at bits [k*W +: W].
REQ-009 SHALL have port result_ARGMAX  output  3  index (0..4) of the largest score.
REQ-010 SHALL have port result_TVALID  output  1  result word valid.
REQ-011 SHALL have port result_TREADY  input  1  downstream accepts result.
REQ-012 SHALL have port frame_count  output  COUNT_WIDTH  number of results delivered since reset.

Function
REQ-013 SHALL implement states COLLECT, ARGMAX, OUTPUT; reset state COLLECT.
REQ-014 In COLLECT, cnn_output_k_TREADY SHALL equal NOT captured[k]; in ARGMAX/OUTPUT all TREADY SHALL be 0.
REQ-015 Channel k handshake (TVALID & TREADY high at an edge) SHALL store TDATA into slot k and set captured[k]; channels are independent, any arrival order, any number per cycle.
REQ-016 A channel already captured SHALL NOT be re-sampled until the current result is delivered (per-channel backpressure, no overwrite).
REQ-017 On the edge where the last uncaptured channel(s) handshake, state SHALL go COLLECT -> ARGMAX, including when all five arrive in the same cycle.
REQ-018 ARGMAX SHALL last exactly 4 cycles, comparing slot i (i = 1..4, one per cycle, ascending) against the running max (initialised to slot 0, index 0) using signed comparison.
REQ-019 Running max SHALL update only on strictly greater; ties keep the lower index.
REQ-020 After the 4th ARGMAX edge, state SHALL be OUTPUT; result_TVALID SHALL rise 4 edges after the final-capture edge.
REQ-021 In OUTPUT, result_TVALID SHALL be 1 and result_TDATA/result_ARGMAX SHALL be stable until handshake.
REQ-022 On result handshake: state -> COLLECT, captured[] cleared, frame_count incremented by 1 (wraps from 2^COUNT_WIDTH-1 to 0); TREADYs reassert the following cycle.
REQ-023 result_TVALID SHALL be 0 in COLLECT and ARGMAX; result_TREADY is ignored outside OUTPUT.
REQ-024 Throughput: minimum 6 cycles per result (1 collect + 4 argmax + 1 output).

Reset
REQ-025 While ap_rst_n is low: state COLLECT, captured[] = 0, all TREADY = 0, result_TVALID = 0, result_TDATA = 0, result_ARGMAX = 0, frame_count = 0, asynchronously.
REQ-026 Assertion of ap_rst_n mid-collection, mid-ARGMAX or during OUTPUT SHALL discard partial data with no result emitted and frame_count = 0.
REQ-027 TREADYs SHALL assert on the first rising edge after ap_rst_n deasserts.

Verification
REQ-028 All five valid same cycle, scores (3, -7, 100, 12, 99), result_TREADY=1 -> result_TVALID 4 cycles later, ARGMAX=2, packed data matches, frame_count 0 -> 1.
REQ-029 Staggered arrival k=4,0,3,1,2 over 5 cycles, score 2 = -1, others = -2048 -> each TREADY drops after its capture, ARGMAX=2, single result.
REQ-030 Ties: all scores = 5 -> ARGMAX=0; scores (-5, 7, 7, -5, 7) -> ARGMAX=1.
REQ-031 result_TREADY held low 10 cycles in OUTPUT while new TVALIDs present -> result stable, all input TREADY = 0, no new capture; release -> accept, next frame collected normally.
REQ-032 Reset asserted after 3 channels captured and again during ARGMAX -> all outputs at reset values, no result, frame_count = 0; next full frame produces correct result.
REQ-033 With COUNT_WIDTH = 2, deliver 5 frames -> frame_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/cnn_output_collector.sv
// Gathers five independent CNN score streams into one frame, finds the index of the
// largest signed score over four cycles, then holds the packed result until it is taken.
module cnn_output_collector #(
   parameter int PIXEL_BIT_WIDTH = 12,
   parameter int COUNT_WIDTH     = 16
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_0_TDATA,
   input  logic                         cnn_output_0_TVALID,
   output logic                         cnn_output_0_TREADY,
   input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_1_TDATA,
   input  logic                         cnn_output_1_TVALID,
   output logic                         cnn_output_1_TREADY,
   input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_2_TDATA,
   input  logic                         cnn_output_2_TVALID,
   output logic                         cnn_output_2_TREADY,
   input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_3_TDATA,
   input  logic                         cnn_output_3_TVALID,
   output logic                         cnn_output_3_TREADY,
   input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_4_TDATA,
   input  logic                         cnn_output_4_TVALID,
   output logic                         cnn_output_4_TREADY,
   output logic [5*PIXEL_BIT_WIDTH-1:0] result_TDATA,
   output logic [2:0]                   result_ARGMAX,
   output logic                         result_TVALID,
   input  logic                         result_TREADY,
   output logic [COUNT_WIDTH-1:0]       frame_count
);

   localparam int N = 5;
   localparam int W = PIXEL_BIT_WIDTH;

   typedef enum logic [1:0] {COLLECT, ARGMAX, OUTPUT} state_t;

   state_t                  state_q, state_d;
   logic                    run_q;
   logic [N-1:0]            captured_q;
   logic signed [W-1:0]     slot_q [N];
   logic [2:0]              cmp_idx_q;
   logic [2:0]              max_idx_q;
   logic [COUNT_WIDTH-1:0]  frame_count_q;

   logic [N-1:0]            in_valid;
   logic [N-1:0]            in_ready;
   logic [N-1:0]            take;
   logic [W-1:0]            in_data [N];
   logic signed [W-1:0]     cand;
   logic signed [W-1:0]     cur_max;
   logic                    all_done;
   logic                    result_hs;

   assign in_valid = {cnn_output_4_TVALID, cnn_output_3_TVALID, cnn_output_2_TVALID,
                      cnn_output_1_TVALID, cnn_output_0_TVALID};
   assign in_data[0] = cnn_output_0_TDATA;
   assign in_data[1] = cnn_output_1_TDATA;
   assign in_data[2] = cnn_output_2_TDATA;
   assign in_data[3] = cnn_output_3_TDATA;
   assign in_data[4] = cnn_output_4_TDATA;

   // run_q keeps every TREADY low until the first edge after reset is released.
   assign in_ready = (state_q == COLLECT && run_q) ? ~captured_q : '0;
   assign take     = in_valid & in_ready;
   assign all_done = &(captured_q | take);
   assign result_hs = (state_q == OUTPUT) && result_TREADY;

   assign cnn_output_0_TREADY = in_ready[0];
   assign cnn_output_1_TREADY = in_ready[1];
   assign cnn_output_2_TREADY = in_ready[2];
   assign cnn_output_3_TREADY = in_ready[3];
   assign cnn_output_4_TREADY = in_ready[4];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      cand    = '0;
      cur_max = '0;
      for (int i = 0; i < N; i++) begin
         if (cmp_idx_q == 3'(i)) cand    = slot_q[i];
         if (max_idx_q == 3'(i)) cur_max = slot_q[i];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         COLLECT: if (all_done)           state_d = ARGMAX;
         ARGMAX:  if (cmp_idx_q == 3'd4)  state_d = OUTPUT;
         OUTPUT:  if (result_TREADY)      state_d = COLLECT;
         default:                         state_d = COLLECT;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q       <= COLLECT;
         run_q         <= 1'b0;
         captured_q    <= '0;
         cmp_idx_q     <= 3'd1;
         max_idx_q     <= 3'd0;
         frame_count_q <= '0;
         // NOTE: the score slots drive result_TDATA directly, so they must reset to zero.
         for (int i = 0; i < N; i++) slot_q[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q <= state_d;
         run_q   <= 1'b1;
         for (int i = 0; i < N; i++) begin
            if (take[i]) slot_q[i] <= in_data[i];
         end
         unique case (state_q)
            COLLECT: begin
               captured_q <= captured_q | take;
               if (all_done) begin
                  cmp_idx_q <= 3'd1;
                  max_idx_q <= 3'd0;
               end
            end
            ARGMAX: begin
               // Strictly greater only, so ties keep the lower index.
               if (cand > cur_max) max_idx_q <= cmp_idx_q;
               cmp_idx_q <= cmp_idx_q + 3'd1;
            end
            OUTPUT: begin
               if (result_hs) begin
                  captured_q    <= '0;
                  frame_count_q <= frame_count_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      result_TDATA = '0;
      for (int i = 0; i < N; i++) result_TDATA[i*W +: W] = slot_q[i];
   end

   assign result_ARGMAX = max_idx_q;
   assign result_TVALID = (state_q == OUTPUT);
   assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_cnn_output_collector.sv
// Directed bench for cnn_output_collector: argmax, ties, staggered arrival, backpressure,
// mid-frame reset and frame counter wrap with a 2-bit counter.
module tb_cnn_output_collector;

   localparam int W  = 12;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  tdata [5];
   logic [4:0]    tvalid;
   wire  [4:0]    tready;
   wire  [5*W-1:0] r_data;
   wire  [2:0]    r_arg;
   wire           r_valid;
   logic          r_ready;
   wire  [CW-1:0] fc;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [CW-1:0] exp_fc   = '0;

   always #5 clk = ~clk;

   cnn_output_collector #(.PIXEL_BIT_WIDTH(W), .COUNT_WIDTH(CW)) dut (
      .ap_clk              (clk),
      .ap_rst_n            (rst_n),
      .cnn_output_0_TDATA  (tdata[0]), .cnn_output_0_TVALID(tvalid[0]), .cnn_output_0_TREADY(tready[0]),
      .cnn_output_1_TDATA  (tdata[1]), .cnn_output_1_TVALID(tvalid[1]), .cnn_output_1_TREADY(tready[1]),
      .cnn_output_2_TDATA  (tdata[2]), .cnn_output_2_TVALID(tvalid[2]), .cnn_output_2_TREADY(tready[2]),
      .cnn_output_3_TDATA  (tdata[3]), .cnn_output_3_TVALID(tvalid[3]), .cnn_output_3_TREADY(tready[3]),
      .cnn_output_4_TDATA  (tdata[4]), .cnn_output_4_TVALID(tvalid[4]), .cnn_output_4_TREADY(tready[4]),
      .result_TDATA        (r_data),
      .result_ARGMAX       (r_arg),
      .result_TVALID       (r_valid),
      .result_TREADY       (r_ready),
      .frame_count         (fc)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5*W-1:0] pack5(input int s0, input int s1, input int s2,
                                             input int s3, input int s4);
      logic [5*W-1:0] p;
      p[0*W +: W] = s0[W-1:0];
      p[1*W +: W] = s1[W-1:0];
      p[2*W +: W] = s2[W-1:0];
      p[3*W +: W] = s3[W-1:0];
      p[4*W +: W] = s4[W-1:0];
      return p;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tready"}, 64'(tready), 64'h0);
      check({tag, "_tvalid"}, 64'(r_valid), 64'h0);
      check({tag, "_tdata"},  64'(r_data), 64'h0);
      check({tag, "_argmax"}, 64'(r_arg), 64'h0);
      check({tag, "_fc"},     64'(fc), 64'h0);
   endtask

   // Asserts reset away from an edge, checks the asynchronous values, then releases it.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      step();
      check_reset_outputs({tag, "_held"});
      rst_n = 1'b1;
      exp_fc = '0;
      #1;
      check({tag, "_tready_pre_edge"}, 64'(tready), 64'h0);
      step();
      check({tag, "_tready_post_edge"}, 64'(tready), 64'h1f);
   endtask

   // Called right after the final-capture edge: checks latency, payload and handshake.
   task automatic finish_frame(input logic [5*W-1:0] sc, input logic [2:0] exp_arg,
                               input string tag);
      int lat;
      lat = 0;
      check({tag, "_tready_argmax"}, 64'(tready), 64'h0);
      while (!r_valid && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd4);
      check({tag, "_data"},    64'(r_data), 64'(sc));
      check({tag, "_argmax"},  64'(r_arg), 64'(exp_arg));
      r_ready = 1'b1;
      step();
      exp_fc = exp_fc + 1'b1;
      check({tag, "_fc"},          64'(fc), 64'(exp_fc));
      check({tag, "_tvalid_done"}, 64'(r_valid), 64'h0);
      check({tag, "_tready_back"}, 64'(tready), 64'h1f);
   endtask

   task automatic do_frame(input logic [5*W-1:0] sc, input logic [2:0] exp_arg,
                           input string tag);
      for (int k = 0; k < 5; k++) tdata[k] = sc[k*W +: W];
      tvalid  = 5'h1f;
      r_ready = 1'b1;
      step();
      tvalid = 5'h00;
      finish_frame(sc, exp_arg, tag);
   endtask

   initial begin
      logic [5*W-1:0] sc;
      logic [5*W-1:0] sc_b;
      logic [4:0]     exp_rdy;
      int             order [5];
      int             wait_cnt;

      rst_n   = 1'b0;
      tvalid  = 5'h00;
      r_ready = 1'b0;
      for (int k = 0; k < 5; k++) tdata[k] = '0;
      #3;
      check_reset_outputs("por");
      step();
      rst_n = 1'b1;
      #1;
      check("por_tready_pre_edge", 64'(tready), 64'h0);
      step();
      check("por_tready_post_edge", 64'(tready), 64'h1f);

      // All five in one cycle.
      do_frame(pack5(3, -7, 100, 12, 99), 3'd2, "same_cycle");

      // Staggered arrival 4,0,3,1,2.
      sc = pack5(-2048, -2048, -1, -2048, -2048);
      order = '{4, 0, 3, 1, 2};
      exp_rdy = 5'h1f;
      r_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tvalid = 5'h00;
         tvalid[order[i]] = 1'b1;
         tdata[order[i]] = sc[order[i]*W +: W];
         step();
         exp_rdy[order[i]] = 1'b0;
         check($sformatf("stagger_tready_%0d", i), 64'(tready), 64'(exp_rdy));
      end
      tvalid = 5'h00;
      finish_frame(sc, 3'd2, "stagger");
      step();
      check("stagger_single_result", 64'(r_valid), 64'h0);

      // Ties (counter wraps 3 -> 0 on the second).
      do_frame(pack5(5, 5, 5, 5, 5), 3'd0, "tie_all");
      do_frame(pack5(-5, 7, 7, -5, 7), 3'd1, "tie_mixed");

      // Downstream backpressure with new input offered.
      sc   = pack5(10, 20, -30, 40, -50);
      sc_b = pack5(1, 2, 3, 4, 5);
      for (int k = 0; k < 5; k++) tdata[k] = sc[k*W +: W];
      tvalid  = 5'h1f;
      r_ready = 1'b0;
      step();
      tvalid = 5'h00;
      wait_cnt = 0;
      while (!r_valid && wait_cnt < 20) begin
         step();
         wait_cnt++;
      end
      check("bp_latency", 64'(wait_cnt), 64'd4);
      for (int k = 0; k < 5; k++) tdata[k] = sc_b[k*W +: W];
      tvalid = 5'h1f;
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("bp_hold_valid_%0d", i),  64'(r_valid), 64'h1);
         check($sformatf("bp_hold_data_%0d", i),   64'(r_data), 64'(sc));
         check($sformatf("bp_hold_arg_%0d", i),    64'(r_arg), 64'd3);
         check($sformatf("bp_hold_tready_%0d", i), 64'(tready), 64'h0);
      end
      check("bp_hold_fc", 64'(fc), 64'(exp_fc));
      tvalid  = 5'h00;
      r_ready = 1'b1;
      step();
      exp_fc = exp_fc + 1'b1;
      check("bp_release_fc", 64'(fc), 64'(exp_fc));
      check("bp_release_tready", 64'(tready), 64'h1f);
      do_frame(sc_b, 3'd4, "bp_next");

      // Reset after three captures, then again in ARGMAX.
      for (int k = 0; k < 5; k++) tdata[k] = 12'h123;
      tvalid = 5'b00111;
      step();
      check("rst_partial_tready", 64'(tready), 64'b11000);
      tvalid = 5'h00;
      do_reset("rst_collect");
      tvalid = 5'h1f;
      step();
      tvalid = 5'h00;
      step();
      step();
      do_reset("rst_argmax");
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("rst_no_result_%0d", i), 64'(r_valid), 64'h0);
      end
      do_frame(pack5(3, -7, 100, 12, 99), 3'd2, "after_rst");

      // Counter wrap sequence 1, 2, 3, 0, 1.
      do_reset("rst_wrap");
      do_frame(pack5(0, 0, 0, 0, 1), 3'd4, "wrap1");
      do_frame(pack5(-1, -2, -3, -4, -5), 3'd0, "wrap2");
      do_frame(pack5(2047, -2048, 2047, 0, 0), 3'd0, "wrap3");
      do_frame(pack5(-2048, -2048, -2048, -2048, -2047), 3'd4, "wrap4");
      do_frame(pack5(5, 5, 5, 5, 5), 3'd0, "wrap5");
      check("wrap_final_fc", 64'(fc), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
